// File: rtl/keypad_encoder_n.sv
// ---------------------------------------------------------------------------
// keypad_encoder_n
//
// Keypad front-end for the microwave controller. Encodes NUM_KEYS active-high
// key lines with a highest-index-wins priority encoder, debounces the press,
// issues a single load strobe per accepted key, suppresses held keys, and
// debounces the release. In counting mode it generates a divided timing tick
// on pgt_1hz as a synchronous pulse.
//
// Optional feature macro: KEYPAD_AUTO_REPEAT_EN
//   When defined, a key held in entry mode re-issues the load strobe every
//   REPEAT_CYCLES cycles. When undefined, the repeat logic is not built.
//
// Ports:
//   clk      in   1         system clock, rising edge
//   reset    in   1         synchronous active-high reset
//   keypad   in   NUM_KEYS  active-high key lines (already synchronised)
//   enablen  in   1         0 = entry mode, 1 = counting mode
//   D        out  CODE_W    last loaded key code
//   loadn    out  1         active-low one-cycle load strobe, aligned with D
//   key_held out  1         high while an accepted key stays pressed
//   pgt_1hz  out  1         one-cycle pulse: load event or divider tick
// ---------------------------------------------------------------------------
module keypad_encoder_n #(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 7,
  parameter int TICK_DIV        = 50000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enablen,
  output logic [CODE_W-1:0]   D,
  output logic                loadn,
  output logic                key_held,
  output logic                pgt_1hz
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(TICK_DIV);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("keypad_encoder_n: DEBOUNCE_CYCLES must be >= 1");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("keypad_encoder_n: TICK_DIV must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("keypad_encoder_n: REPEAT_CYCLES must be >= 2");
  end
  if (CODE_W < $clog2(NUM_KEYS)) begin : g_bad_code_w
    $error("keypad_encoder_n: CODE_W too narrow for NUM_KEYS");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_LOAD     = 3'd2,
    S_HELD     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CODE_W-1:0]  w_code;
  logic               w_any_key;
  logic [CODE_W-1:0]  r_cand;
  logic [CODE_W-1:0]  w_next_cand;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic [DIV_W-1:0]   r_div;
  logic               w_tick;
  logic               w_repeat;
  logic               w_load_evt;
  logic [CODE_W-1:0]  r_d;
  logic               r_loadn;
  logic               r_key_held;
  logic               r_pgt;

  // -------------------------------------------------------------------------
  // Priority encoder: scanning upward lets the highest asserted index win.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    w_code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keypad[i]) w_code = CODE_W'(i);
    end
  end

  assign w_any_key = |keypad;

  // -------------------------------------------------------------------------
  // Next-state logic. Counters compare against DEBOUNCE_CYCLES-1 so the state
  // change lands on the same edge at which the count would reach
  // DEBOUNCE_CYCLES; this gives loadn low exactly DEBOUNCE_CYCLES cycles after
  // the first pressed cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_cand  = r_cand;
    case (r_state)
      S_IDLE: begin
        if (!enablen && w_any_key) begin
          w_next_cand = w_code;
          w_next_cnt  = CNT_W'(1);
          // A single-cycle debounce has already been satisfied by this cycle.
          w_next_state = (DEBOUNCE_CYCLES == 1) ? S_LOAD : S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (enablen || !w_any_key || (w_code != r_cand)) begin
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          w_next_state = S_LOAD;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      S_LOAD: begin
        w_next_state = S_HELD;
        w_next_cnt   = '0;
      end
      S_HELD: begin
        // Code changes while any key is down are ignored: only a full release
        // re-arms the encoder. This also holds in counting mode.
        if (!w_any_key) begin
          w_next_state = (DEBOUNCE_CYCLES == 1) ? S_IDLE : S_RELEASE;
          w_next_cnt   = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (w_any_key) begin
          w_next_state = S_HELD;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          w_next_state = S_IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // A load event happens on entry to LOAD or on an auto-repeat pulse. Both
  // require enablen=0, so they can never coincide with a divider tick.
  assign w_load_evt = (w_next_state == S_LOAD) || w_repeat;

  // -------------------------------------------------------------------------
  // State and output registers. Outputs are computed from the next state so
  // they are registered yet aligned with the state they describe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cand     <= '0;
      r_d        <= '0;
      r_loadn    <= 1'b1;
      r_key_held <= 1'b0;
      r_pgt      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_cand     <= w_next_cand;
      if (w_load_evt) r_d <= w_next_cand;
      r_loadn    <= ~w_load_evt;
      r_key_held <= (w_next_state == S_HELD);
      r_pgt      <= w_load_evt | w_tick;
    end
  end

  // -------------------------------------------------------------------------
  // Tick divider. Held at zero in entry mode; in counting mode the registered
  // pulse follows the terminal count, so the first tick appears TICK_DIV
  // cycles after enablen rises.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (!enablen) begin
      r_div <= '0;
    end else if (r_div == DIV_W'(TICK_DIV - 1)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = enablen && (r_div == DIV_W'(TICK_DIV - 1));

  // -------------------------------------------------------------------------
  // Auto-repeat. The counter sits at zero outside HELD, so it restarts on
  // every entry to HELD, and it is cleared whenever counting mode is active.
  // -------------------------------------------------------------------------
`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);

  logic [REP_W-1:0] r_rep;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep <= '0;
    end else if ((r_state != S_HELD) || enablen) begin
      r_rep <= '0;
    end else if (r_rep == REP_W'(REPEAT_CYCLES - 1)) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end

  // Only repeat while the key is still down, i.e. while HELD is kept.
  assign w_repeat = (r_state == S_HELD) && !enablen && w_any_key &&
                    (r_rep == REP_W'(REPEAT_CYCLES - 1));
`else
  assign w_repeat = 1'b0;
`endif

  assign D        = r_d;
  assign loadn    = r_loadn;
  assign key_held = r_key_held;
  assign pgt_1hz  = r_pgt;

endmodule

// File: doc/keypad_encoder_n.md
Name: keypad_encoder_n

Overview:
- Parametrised keypad front-end for the microwave controller: N-key priority encoder with a debounce/hold state machine, a one-cycle load strobe and a divided timing tick.
- Sits between the raw keypad inputs and the digit/time register chain. It replaces the fixed 10-key encoder, which had a free mod-7 delay and no release tracking.
- Adds debounce, held-key suppression, release debounce and synchronous tick pulses instead of a muxed clock.

Parameters:
- NUM_KEYS, 10, number of keypad lines; key index i encodes to value i.
- CODE_W, 4, width of D; must be >= clog2(NUM_KEYS).
- DEBOUNCE_CYCLES, 7, consecutive stable cycles required on press and on release (>=1).
- TICK_DIV, 50000000, clk cycles per pgt_1hz tick in counting mode (>=2).
- REPEAT_CYCLES, 25000000, auto-repeat interval; used only with KEYPAD_AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- keypad  input  NUM_KEYS  active-high key lines, already synchronised
- enablen  input  1  0 = entry mode (keys accepted), 1 = counting mode (keys ignored, tick runs)
- D  output  CODE_W  last loaded key code
- loadn  output  1  active-low one-cycle load strobe, aligned with the D update
- key_held  output  1  high while an accepted key remains pressed (HELD state)
- pgt_1hz  output  1  one-cycle high pulse: a load event in entry mode, a divider tick in counting mode

Behaviour:
- Reset values: D=0, loadn=1, key_held=0, pgt_1hz=0, state=IDLE, all counters=0.
- Encoder (combinational, internal): the highest-index asserted key wins. any_key = OR of keypad.
- FSM states and transitions:
  - IDLE: if enablen=0 and any_key, capture the code into cand and go to DEBOUNCE with cnt=1.
  - DEBOUNCE: each cycle the encoded code equals cand and any_key=1, cnt++. When cnt reaches DEBOUNCE_CYCLES, go to LOAD. On a code change, release, or enablen=1, go to IDLE and output nothing.
  - LOAD: one cycle. D<=cand, loadn=0, pgt_1hz=1. Then go to HELD.
  - HELD: key_held=1. No new loads, even if the code changes while any key is still down. When any_key=0, go to RELEASE with cnt=1.
  - RELEASE: count consecutive any_key=0 cycles. At DEBOUNCE_CYCLES go to IDLE. Any key re-asserted returns to HELD with cnt cleared.
- Latency: first any_key cycle T, so cand is captured at the T edge. loadn is low during cycle T+DEBOUNCE_CYCLES. D is valid from that cycle and holds until the next LOAD.
- enablen=1 during HELD/RELEASE: the FSM still completes release tracking (no load possible). This prevents a key held across a mode switch from loading on return.
- Divider: while enablen=0 the divider is held at 0. While enablen=1 it counts 0..TICK_DIV-1 and wraps. pgt_1hz=1 in the cycle the count equals TICK_DIV-1. The first tick occurs TICK_DIV cycles after enablen rises.
- pgt_1hz is never high for more than one consecutive cycle. LOAD and a tick cannot coincide, because LOAD requires enablen=0.
- reset asserted mid-operation: next edge forces the reset values regardless of state. D returns to 0.
- loadn, key_held and pgt_1hz are registered outputs with no combinational path from keypad.

Optional Feature:
- KEYPAD_AUTO_REPEAT_EN defined:
  - In HELD with enablen=0, a repeat counter runs. Every REPEAT_CYCLES cycles it issues another LOAD-equivalent pulse (loadn=0, pgt_1hz=1, D<=cand) for the originally accepted code.
  - The counter clears on entering HELD and whenever enablen=1.
- Not defined: HELD issues no further strobes, and the repeat counter logic is absent.

Test Plan (NUM_KEYS=10, DEBOUNCE_CYCLES=3, TICK_DIV=5, REPEAT_CYCLES=8):
- Reset, then press key 7 alone at cycle 0 with enablen=0 -> loadn low only in cycle 3, D=7 from cycle 3, pgt_1hz=1 in cycle 3, key_held=1 from cycle 4.
- Press keys 2 and 9 together -> D=9. Bounce key 4 high for 2 cycles then low -> no loadn pulse, D unchanged.
- Hold key 5 for 20 cycles, release for 2 cycles, press again, release for 3 cycles -> exactly one loadn pulse, and IDLE only after the 3rd clean release cycle. With KEYPAD_AUTO_REPEAT_EN, extra pulses appear at 8 and 16 cycles into HELD.
- Set enablen=1 for 12 cycles -> pgt_1hz pulses at cycles 5 and 10 after the rise. Keys pressed during this window produce no loadn.
- Press key 3, then raise enablen at debounce cycle 2 -> no load, FSM returns to IDLE, D unchanged.
- Assert reset during HELD with D=6 -> next cycle D=0, loadn=1, key_held=0. With the key still pressed after reset, a fresh debounce yields a new load after 3 cycles.
